// File: rtl/keypad_cmd_enc.sv
// 4x4 matrix keypad scanner: synchronizes the rows, debounces presses and releases,
// and emits one cmd_valid pulse with cmd = 4*row + col per physical press.
module keypad_cmd_enc #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] cmd,
  output logic       cmd_valid
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, EMIT, WAIT_REL} state_t;

  state_t        state, state_nx;
  logic [3:0]    row_m, row_s;
  logic [CW-1:0] dwell;
  logic          sample;
  logic [DW-1:0] deb_cnt, deb_nx, deb_inc;
  logic [1:0]    col;
  logic          col_adv;
  logic [3:0]    key;
  logic [3:0]    hit_key;
  logic [1:0]    hit_row;
  logic          hit;

  assign sample  = (dwell == DWELL_LAST);
  assign deb_inc = deb_cnt + DW'(1);

  // Lowest-numbered low row wins when several rows are pulled down together.
  always_comb begin
    hit     = (row_s != 4'hF);
    hit_row = 2'd0;
    if (!row_s[0])      hit_row = 2'd0;
    else if (!row_s[1]) hit_row = 2'd1;
    else if (!row_s[2]) hit_row = 2'd2;
    else if (!row_s[3]) hit_row = 2'd3;
    hit_key = {hit_row, col};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= SCAN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    deb_nx   = deb_cnt;
    col_adv  = 1'b0;
    case (state)
      SCAN: begin
        if (sample) begin
          if (hit) begin
            deb_nx   = DW'(1);
            state_nx = (DEBOUNCE == 1) ? EMIT : DEB_PRESS;
          end else begin
            col_adv = 1'b1;
          end
        end
      end
      DEB_PRESS: begin
        if (sample) begin
          if (hit && (hit_key == key)) begin
            deb_nx = deb_inc;
            if (deb_inc == DEB_MAX) state_nx = EMIT;
          end else begin
            deb_nx   = '0;
            state_nx = SCAN;
            col_adv  = 1'b1;
          end
        end
      end
      EMIT: begin
        deb_nx   = '0;
        state_nx = WAIT_REL;
      end
      WAIT_REL: begin
        if (sample) begin
          if (hit) begin
            deb_nx = '0;
          end else if (deb_inc == DEB_MAX) begin
            deb_nx   = '0;
            state_nx = SCAN;
            col_adv  = 1'b1;
          end else begin
            deb_nx = deb_inc;
          end
        end
      end
      default: state_nx = SCAN;
    endcase
  end

  always_comb begin
    col_out   = ~(4'b0001 << col);
    cmd_valid = (state == EMIT);
  end

  // cmd is loaded on the edge into EMIT so it is already stable while cmd_valid is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_m   <= '1;
      row_s   <= '1;
      dwell   <= '0;
      deb_cnt <= '0;
      col     <= '0;
      key     <= '0;
      cmd     <= '0;
    end else begin
      row_m   <= row_in;
      row_s   <= row_m;
      dwell   <= (state == EMIT || sample) ? '0 : dwell + CW'(1);
      deb_cnt <= deb_nx;
      if (col_adv) col <= col + 2'd1;
      if (state == SCAN && sample && hit) key <= hit_key;
      if (state_nx == EMIT && state != EMIT) cmd <= hit_key;
    end
  end

endmodule

// File: tb/tb_keypad_cmd_enc.sv
// Bench for keypad_cmd_enc: a keypad model drives the rows from the column drive, and a
// sample-level reference model is compared against the DUT outputs every cycle.
module tb_keypad_cmd_enc;

  localparam int SD = 4;
  localparam int DB = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  cmd;
  logic        cmd_valid;

  int tests = 0;
  int errors = 0;
  int npulse = 0;
  int last_cmd = 0;

  keypad_cmd_enc #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .cmd       (cmd),
    .cmd_valid (cmd_valid)
  );

  always #5 clock = ~clock;

  // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
  function automatic logic [3:0] keypad(input logic [15:0] p, input logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (p[4*rr+cc] && !cols[cc]) r[rr] = 1'b0;
    return r;
  endfunction

  assign row_in = keypad(pressed, col_out);

  // Reference model: tracks sample instants, the scanned column, a streak of agreeing
  // samples and whether we are waiting for release.
  int         m_dwell = 0, m_col = 0, m_streak = 0, m_key = 0, m_cmd = 0, m_r;
  bit         m_locked = 0, m_valid = 0, m_emit_was, m_sample, m_hit;
  logic [3:0] s1 = '1, s2 = '1, m_rows;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_dwell = 0; m_col = 0; m_streak = 0; m_key = 0; m_cmd = 0;
      m_locked = 0; m_valid = 0; s1 = '1; s2 = '1;
    end else begin
      m_emit_was = m_valid;
      m_valid    = 0;
      m_sample   = (m_dwell == SD - 1);
      m_dwell    = (m_emit_was || m_sample) ? 0 : m_dwell + 1;
      m_rows     = s2;
      s2         = s1;
      s1         = row_in;
      if (m_sample) begin
        m_hit = (m_rows != 4'hF);
        m_r   = 0;
        for (int i = 3; i >= 0; i--) if (!m_rows[i]) m_r = i;
        if (!m_locked) begin
          if (m_streak == 0) begin
            if (m_hit) begin m_key = 4*m_r + m_col; m_streak = 1; end
            else m_col = (m_col + 1) % 4;
          end else if (m_hit && (4*m_r + m_col == m_key)) begin
            m_streak++;
          end else begin
            m_streak = 0; m_col = (m_col + 1) % 4;
          end
          if (m_streak == DB) begin
            m_cmd = m_key; m_valid = 1; m_locked = 1; m_streak = 0;
          end
        end else begin
          if (m_hit) m_streak = 0; else m_streak++;
          if (m_streak == DB) begin
            m_locked = 0; m_streak = 0; m_col = (m_col + 1) % 4;
          end
        end
      end
    end
  end

  logic [3:0] exp_col;
  always @(negedge clock) begin
    exp_col = ~(4'b0001 << m_col);
    tests++;
    if (col_out !== exp_col || cmd !== 4'(m_cmd) || cmd_valid !== m_valid) begin
      errors++;
      $display("FAIL cycle_model t=%0t col_out got %b exp %b, cmd got %0d exp %0d, cmd_valid got %b exp %b",
               $time, col_out, exp_col, cmd, m_cmd, cmd_valid, m_valid);
    end
    if (cmd_valid) begin
      npulse++;
      last_cmd = cmd;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] target, input int budget);
    int k;
    k = 0;
    while (col_out !== target && k < budget) begin step(1); k++; end
    check("wait_col_budget", int'(col_out == target), 1);
  endtask

  int base;
  int hold;

  initial begin
    #2 reset = 1'b0;
    step(3);
    reset = 1'b1;

    // 1: idle scan
    step(2);  check("idle_col0", col_out, 4'b1110);
    step(4);  check("idle_col1", col_out, 4'b1101);
    step(4);  check("idle_col2", col_out, 4'b1011);
    step(4);  check("idle_col3", col_out, 4'b0111);
    step(4);  check("idle_wrap", col_out, 4'b1110);
    check("idle_no_pulse", npulse, 0);

    // 2: clean press of key 6, held 200 clocks
    step($urandom_range(0, 7));
    base = npulse;
    pressed[6] = 1'b1;
    step(200);
    check("k6_col_frozen", col_out, 4'b1011);
    check("k6_pulses", npulse - base, 1);
    check("k6_cmd", last_cmd, 6);
    pressed = '0;
    step(30);

    // 3: bouncing key 0, aligned to the start of the col0 dwell
    wait_col(4'b0111, 40);
    wait_col(4'b1110, 40);
    base = npulse;
    for (int i = 0; i < 40; i++) begin
      pressed[0] = ((i / 3) % 2 == 0);
      step(1);
    end
    pressed[0] = 1'b1;
    check("bounce_no_pulse", npulse - base, 0);
    step(60);
    check("bounce_pulses", npulse - base, 1);
    check("bounce_cmd", last_cmd, 0);
    pressed = '0;
    step(30);

    // 4: rows 1 and 3 on col3 together
    base = npulse;
    pressed[7] = 1'b1;
    pressed[15] = 1'b1;
    step(60);
    check("multi_pulses", npulse - base, 1);
    check("multi_cmd", last_cmd, 7);
    pressed = '0;
    wait_col(4'b1110, 40);
    check("multi_resume_col0", col_out, 4'b1110);
    step(20);

    // 5: second key while first held is ignored
    base = npulse;
    pressed[5] = 1'b1;
    step(60);
    check("k5_pulses", npulse - base, 1);
    check("k5_cmd", last_cmd, 5);
    pressed[10] = 1'b1;
    step(40);
    pressed[5] = 1'b0;
    step(2);
    pressed[10] = 1'b0;
    step(40);
    check("k10_ignored", npulse - base, 1);
    pressed[10] = 1'b1;
    step(60);
    check("k10_again_pulses", npulse - base, 2);
    check("k10_again_cmd", last_cmd, 10);
    pressed = '0;
    step(30);

    // 6: reset while waiting for release of key 9
    base = npulse;
    pressed[9] = 1'b1;
    step(60);
    check("k9_pulses", npulse - base, 1);
    step(5);
    reset = 1'b0;
    step(1);
    check("rst_col_out", col_out, 4'b1110);
    check("rst_cmd", cmd, 0);
    check("rst_valid", cmd_valid, 0);
    step(2);
    reset = 1'b1;
    base = npulse;
    step(60);
    check("k9_after_rst_pulses", npulse - base, 1);
    check("k9_after_rst_cmd", last_cmd, 9);
    pressed = '0;
    step(30);

    // random presses, chords, glitches and occasional resets
    for (int it = 0; it < 60; it++) begin
      pressed = '0;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        pressed[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 50);
      step(hold);
      if ($urandom_range(0, 4) == 0) begin
        pressed = pressed ^ 16'(1 << $urandom_range(0, 15));
        step($urandom_range(1, 2));
      end
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        step($urandom_range(1, 3));
        reset = 1'b1;
      end
    end
    pressed = '0;
    step(40);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
